dffram_arbiter: RTL and testbench
=================================

DFFRAM_ARBITER -- requirements
Module: dffram_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h2000_0000, byte base address of the shared RAM.
REQ-002 Parameter AW, default 12, RAM word-address width; RAM window = 4*2^AW bytes (16 KiB).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low: clk_i (in, 1) and rst_ni (in, 1).
REQ-004 Port A (instruction): a_req_i in 1, a_we_i in 1, a_be_i in 4, a_addr_i in 32 (byte address), a_wdata_i in 32.
REQ-005 Port A response: a_gnt_o out 1, a_rvalid_o out 1, a_rdata_o out 32, a_err_o out 1.
REQ-006 Port B (data): b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i, b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o, with the same widths and meanings as Port A.
REQ-007 RAM side: mem_en_o out 1, mem_we_o out 4 (byte write mask), mem_a_o out AW (word address), mem_di_o out 32, mem_do_i in 32.
REQ-008 The RAM behind mem_* is single-port, with synchronous read: mem_do_i is valid one clock after mem_en_o.

Function
REQ-009 Grant is combinational, in the request cycle: at most one of a_gnt_o/b_gnt_o is high per cycle, and gnt is never high without the matching req.
REQ-010 Single requester: granted in the same cycle.
REQ-011 Both requesting: round-robin; grant goes to the port not granted most recently.
REQ-012 The register last_gnt (A/B) updates only on a cycle with a grant.
REQ-013 After reset, last_gnt = B, so A wins the first conflict.
REQ-014 Non-granted requester: keeps req and its payload stable until granted; the block holds no request queue.
REQ-015 Access is valid when addr >= BASE_ADDR, addr < BASE_ADDR + 4*2^AW, and addr[1:0] == 2'b00.
REQ-016 Valid granted access: mem_en_o=1, mem_a_o=(addr-BASE_ADDR)[AW+1:2], mem_di_o=wdata, mem_we_o = we ? be : 4'b0.
REQ-017 Invalid granted access: mem_en_o=0 and mem_we_o=0; the RAM is not touched.
REQ-018 No grant: mem_en_o=0, mem_we_o=0, mem_a_o=0, mem_di_o=0.
REQ-019 Response latency: exactly 1 cycle after grant, rvalid_o=1 for one cycle on the granted port only, for reads and writes alike.
REQ-020 Response registers capture: port id, we, and error flag of the granted access.
REQ-021 Response data: rdata_o = mem_do_i for a valid read; otherwise rdata_o = 32'h0.
REQ-022 rdata_o = 32'h0 whenever rvalid_o is low.
REQ-023 err_o = 1 with rvalid_o for an invalid access; otherwise err_o = 0.
REQ-024 Back-to-back: a new grant in the same cycle as the previous rvalid is allowed, giving full throughput of 1 access/cycle.
REQ-025 The idle port's rvalid_o, rdata_o and err_o stay 0.
REQ-026 Writes with be=4'b0000 are valid no-op accesses: rvalid=1, err=0, mem_en_o=1, mem_we_o=0.
REQ-027 Address arithmetic uses full 32-bit unsigned compares; the range end is exclusive and there is no wrap-around.

Reset
REQ-028 While rst_ni is low: all response outputs are 0 and last_gnt = B.
REQ-029 The mem_* outputs follow REQ-018 while the combinational grant is forced 0.
REQ-030 Reset asserted mid-access: the pending rvalid is dropped, and no response issues after reset release.
REQ-031 The first grant is possible in the first cycle with rst_ni high.

Verification
REQ-032 The bench SHALL cover: A write 0x2000_0010, data 0xDEAD_BEEF, be=4'hF -> mem_en=1, mem_a=12'h004, mem_we=4'hF; next cycle a_rvalid=1, a_err=0.
REQ-033 The bench SHALL cover: B read 0x2000_0010 after the write above -> next cycle b_rvalid=1, b_rdata=0xDEAD_BEEF; a_rvalid=0.
REQ-034 The bench SHALL cover: A and B requesting continuously from reset -> grants A,B,A,B on successive cycles; rvalid on each port every other cycle.
REQ-035 The bench SHALL cover the following error cases, each giving mem_en=0 and err=1 one cycle later with rdata=0:
- B read 0x2000_4000 (one past the end);
- B read 0x1FFF_FFFC (below base);
- A read 0x2000_0002 (misaligned).
REQ-036 The bench SHALL cover: B write, be=4'b0100, data 0x0055_0000, to word 0x2000_0010 holding 0xDEAD_BEEF -> subsequent read returns 0xDE55_BEEF.
REQ-037 The bench SHALL cover: A read granted, then rst_ni low the next cycle before the clock edge -> a_rvalid stays 0; after release, first conflict is granted to A.

Source files
------------

// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one single-port, synchronous-read RAM between an
// instruction port (A) and a data port (B), with a fixed one-cycle response.
module dffram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          AW        = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // Port A (instruction)
  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic [3:0]    a_be_i,
  input  logic [31:0]   a_addr_i,
  input  logic [31:0]   a_wdata_i,
  output logic          a_gnt_o,
  output logic          a_rvalid_o,
  output logic [31:0]   a_rdata_o,
  output logic          a_err_o,
  // Port B (data)
  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic [3:0]    b_be_i,
  input  logic [31:0]   b_addr_i,
  input  logic [31:0]   b_wdata_i,
  output logic          b_gnt_o,
  output logic          b_rvalid_o,
  output logic [31:0]   b_rdata_o,
  output logic          b_err_o,
  // RAM side
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_a_o,
  output logic [31:0]   mem_di_o,
  input  logic [31:0]   mem_do_i
);

  // Exclusive end of the RAM window, one bit wider so the compare cannot wrap.
  localparam logic [32:0] LP_END_ADDR = {1'b0, BASE_ADDR} + (33'd1 << (AW + 2));

  logic          r_last_b;      // 1: B was granted most recently
  logic          r_rsp_valid;
  logic          r_rsp_b;
  logic          r_rsp_we;
  logic          r_rsp_err;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_gnt;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_valid;
  logic          w_mem_en;
  logic [AW-1:0] w_word;
  logic          w_rd_ok;

  // NOTE: the grant is gated by rst_ni so the RAM stays untouched while reset
  // is held, even though the requesters may already be asserting req.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_ni) begin
      w_gnt_a = a_req_i && (!b_req_i || r_last_b);
      w_gnt_b = b_req_i && !w_gnt_a;
    end
  end

  assign w_gnt   = w_gnt_a || w_gnt_b;
  assign a_gnt_o = w_gnt_a;
  assign b_gnt_o = w_gnt_b;

  // Payload of the winning port; ignored downstream when nothing is granted.
  assign w_we    = w_gnt_b ? b_we_i    : a_we_i;
  assign w_be    = w_gnt_b ? b_be_i    : a_be_i;
  assign w_addr  = w_gnt_b ? b_addr_i  : a_addr_i;
  assign w_wdata = w_gnt_b ? b_wdata_i : a_wdata_i;

  assign w_valid = ({1'b0, w_addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, w_addr} <  LP_END_ADDR) &&
                   (w_addr[1:0] == 2'b00);

  // BASE_ADDR is word aligned, so the word index needs only the word bits.
  assign w_word   = w_addr[AW+1:2] - BASE_ADDR[AW+1:2];
  assign w_mem_en = w_gnt && w_valid;

  assign mem_en_o = w_mem_en;
  assign mem_we_o = (w_mem_en && w_we) ? w_be : 4'b0000;
  assign mem_a_o  = w_gnt ? w_word  : '0;
  assign mem_di_o = w_gnt ? w_wdata : 32'h0;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_b    <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_b     <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_gnt) begin
        r_last_b  <= w_gnt_b;
        r_rsp_b   <= w_gnt_b;
        r_rsp_we  <= w_we;
        r_rsp_err <= !w_valid;
      end
    end
  end

  // Read data arrives from the RAM in the response cycle; passed only for valid reads.
  assign w_rd_ok    = r_rsp_valid && !r_rsp_we && !r_rsp_err;

  assign a_rvalid_o = r_rsp_valid && !r_rsp_b;
  assign b_rvalid_o = r_rsp_valid &&  r_rsp_b;
  assign a_err_o    = a_rvalid_o && r_rsp_err;
  assign b_err_o    = b_rvalid_o && r_rsp_err;
  assign a_rdata_o  = (w_rd_ok && !r_rsp_b) ? mem_do_i : 32'h0;
  assign b_rdata_o  = (w_rd_ok &&  r_rsp_b) ? mem_do_i : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter: a reference model predicts grants and RAM
// strobes, and a queue of expected responses is checked one cycle later.
module tb_dffram_arbiter;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          AW   = 12;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        va;
    logic        vb;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          a_req_i, a_we_i, b_req_i, b_we_i;
  logic [3:0]    a_be_i, b_be_i;
  logic [31:0]   a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
  logic          a_gnt_o, a_rvalid_o, a_err_o, b_gnt_o, b_rvalid_o, b_err_o;
  logic [31:0]   a_rdata_o, b_rdata_o;
  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_a_o;
  logic [31:0]   mem_di_o;
  logic [31:0]   mem_do_i;

  logic [31:0]   ram   [0:(1<<AW)-1];
  logic [31:0]   m_mem [0:(1<<AW)-1];
  logic          m_last_b;
  rsp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            step  = 0;

  always #5 clk_i = ~clk_i;

  dffram_arbiter #(.BASE_ADDR(BASE), .AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_be_i(a_be_i), .a_addr_i(a_addr_i),
    .a_wdata_i(a_wdata_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_be_i(b_be_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o),
    .mem_di_o(mem_di_o), .mem_do_i(mem_do_i)
  );

  // Single-port RAM with byte write mask and synchronous read (old data on write).
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_a_o][8*b +: 8] <= mem_di_o[8*b +: 8];
      mem_do_i <= ram[mem_a_o];
    end
  end

  function automatic req_t rd(input logic [31:0] addr);
    return '{req: 1'b1, we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0};
  endfunction

  function automatic req_t wr(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be);
    return '{req: 1'b1, we: 1'b1, be: be, addr: addr, wdata: data};
  endfunction

  function automatic req_t idle();
    return '{req: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_gnt"},    a_gnt_o,    0);
    check({tag, "_b_gnt"},    b_gnt_o,    0);
    check({tag, "_mem_en"},   mem_en_o,   0);
    check({tag, "_mem_we"},   mem_we_o,   0);
    check({tag, "_mem_a"},    mem_a_o,    0);
    check({tag, "_mem_di"},   mem_di_o,   0);
    check({tag, "_a_rvalid"}, a_rvalid_o, 0);
    check({tag, "_b_rvalid"}, b_rvalid_o, 0);
    check({tag, "_a_rdata"},  a_rdata_o,  0);
    check({tag, "_b_rdata"},  b_rdata_o,  0);
    check({tag, "_a_err"},    a_err_o,    0);
    check({tag, "_b_err"},    b_err_o,    0);
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (sb.size() == 0) e = '{va: 1'b0, vb: 1'b0, err: 1'b0, rdata: 32'h0};
    else e = sb.pop_front();
    check("a_rvalid", a_rvalid_o, e.va);
    check("b_rvalid", b_rvalid_o, e.vb);
    check("a_rdata",  a_rdata_o,  e.va ? e.rdata : 32'h0);
    check("b_rdata",  b_rdata_o,  e.vb ? e.rdata : 32'h0);
    check("a_err",    a_err_o,    e.va & e.err);
    check("b_err",    b_err_o,    e.vb & e.err);
  endtask

  // Drive both ports now, then check grant/RAM strobes and last cycle's response.
  task automatic apply(input req_t a, input req_t b);
    logic        ga, gb, g, v;
    logic [32:0] a33;
    logic [31:0] off;
    logic [11:0] word;
    req_t        s;
    step++;
    a_req_i = a.req; a_we_i = a.we; a_be_i = a.be; a_addr_i = a.addr; a_wdata_i = a.wdata;
    b_req_i = b.req; b_we_i = b.we; b_be_i = b.be; b_addr_i = b.addr; b_wdata_i = b.wdata;
    #1;
    ga   = a.req & (!b.req | m_last_b);
    gb   = b.req & !ga;
    g    = ga | gb;
    s    = gb ? b : a;
    a33  = {1'b0, s.addr};
    v    = (a33 >= {1'b0, BASE}) && (a33 < {1'b0, BASE} + 33'h4000) && (s.addr[1:0] == 2'b00);
    off  = s.addr - BASE;
    word = off[13:2];
    check("a_gnt",  a_gnt_o,  ga);
    check("b_gnt",  b_gnt_o,  gb);
    check("mem_en", mem_en_o, g & v);
    check("mem_we", mem_we_o, (g && v && s.we) ? s.be : 4'h0);
    if (!g) begin
      check("mem_a_idle",  mem_a_o,  0);
      check("mem_di_idle", mem_di_o, 0);
    end else if (v) begin
      check("mem_a",  mem_a_o,  word);
      check("mem_di", mem_di_o, s.wdata);
    end
    check_rsp();
    sb.push_back('{va: ga, vb: gb, err: g & !v,
                   rdata: (g && v && !s.we) ? m_mem[word] : 32'h0});
    if (g && v && s.we)
      for (int b = 0; b < 4; b++)
        if (s.be[b]) m_mem[word][8*b +: 8] = s.wdata[8*b +: 8];
    if (g) m_last_b = gb;
  endtask

  task automatic cycle(input req_t a, input req_t b);
    @(negedge clk_i);
    apply(a, b);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = 32'hC0DE_0000 | i;
      m_mem[i] = 32'hC0DE_0000 | i;
    end
    m_last_b = 1'b1;

    // Reset held with both ports requesting: nothing may be granted or returned.
    {a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i} = rd(32'h2000_0000);
    {b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i} = rd(32'h2000_0004);
    @(negedge clk_i);
    #1;
    check_idle_outputs("reset");

    // Continuous conflict from release: A,B,A,B with alternating responses.
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply(rd(32'h2000_0000), rd(32'h2000_0004));
    check("first_gnt_a", a_gnt_o, 1);
    cycle(rd(32'h2000_0000), rd(32'h2000_0004));
    cycle(rd(32'h2000_0000), rd(32'h2000_0004));
    cycle(rd(32'h2000_0000), rd(32'h2000_0004));

    // Full write, read-back from the other port.
    cycle(wr(32'h2000_0010, 32'hDEAD_BEEF, 4'hF), idle());
    check("wr_mem_a", mem_a_o, 12'h004);
    cycle(idle(), rd(32'h2000_0010));

    // Address errors and the last valid word.
    cycle(idle(), rd(32'h2000_4000));
    cycle(idle(), rd(32'h1FFF_FFFC));
    cycle(rd(32'h2000_0002), idle());
    cycle(idle(), rd(32'h2000_3FFC));
    cycle(wr(32'hFFFF_FFFC, 32'h1234_5678, 4'hF), idle());

    // Byte-lane merge, then a zero-mask write that must leave the word intact.
    cycle(idle(), wr(32'h2000_0010, 32'h0055_0000, 4'b0100));
    cycle(rd(32'h2000_0010), idle());
    check("merge_mem_a", mem_a_o, 12'h004);
    cycle(wr(32'h2000_0010, 32'hFFFF_FFFF, 4'b0000), idle());
    cycle(idle(), rd(32'h2000_0010));

    // Conflicting writes, loser held, then read both back.
    cycle(wr(32'h2000_0100, 32'h1111_1111, 4'hF), wr(32'h2000_0104, 32'h2222_2222, 4'hF));
    cycle(wr(32'h2000_0100, 32'h1111_1111, 4'hF), wr(32'h2000_0104, 32'h2222_2222, 4'hF));
    cycle(rd(32'h2000_0104), rd(32'h2000_0100));
    cycle(rd(32'h2000_0104), rd(32'h2000_0100));
    cycle(idle(), idle());

    // Leave A as last winner, then reset right after an A read is granted.
    cycle(rd(32'h2000_0020), idle());
    cycle(rd(32'h2000_0020), idle());
    check("pre_rst_gnt_a", a_gnt_o, 1);
    rst_ni = 1'b0;
    {a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i} = idle();
    #1;
    check("rst_a_gnt", a_gnt_o, 0);
    check("rst_a_rvalid", a_rvalid_o, 0);
    sb.delete();
    m_last_b = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("midrst");
    rst_ni = 1'b1;
    apply(rd(32'h2000_0024), rd(32'h2000_0028));
    check("post_rst_gnt_a", a_gnt_o, 1);
    cycle(idle(), rd(32'h2000_0028));
    cycle(idle(), idle());
    cycle(idle(), idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
